// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StWrite,
      StWriteAck,
      StRead,
      StReadAck
   } i2c_state_e;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;
   localparam logic ACK      = 1'b0;
   localparam logic NACK     = 1'b1;

   // General call (0x00) and the 10-bit prefix (11110xx) are never answered.
   function automatic logic addr_supported(input logic [6:0] addr);
      return (addr != 7'h00) && (addr[6:2] != 5'b11110);
   endfunction

endpackage

// File: rtl/InOut.sv
// Open-drain capable bidirectional pad: drives dataW when dir is high, else floats.
module InOut (
   inout  wire  PORT,
   input  logic dataW,
   input  logic dir,
   output logic dataR
);

   assign PORT  = dir ? dataW : 1'bz;
   assign dataR = PORT;

endmodule

// File: rtl/i2c_line_sync.sv
// Synchronizer, optional glitch filter and edge detector for one I2C line.
// Optional majority filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_line_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;
   logic       level;

   // Two-flop synchronizer; resets to the idle-high bus level.
   always_comb begin
      sync_d = {sync_q[0], line_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] hist_q, hist_d;
   logic       filt_q, filt_d;

   // Majority of the last three synchronized samples, then registered.
   always_comb begin
      hist_d = {hist_q[0], sync_q[1]};
      filt_d = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hist_q <= 2'b11;
         filt_q <= 1'b1;
      end else begin
         hist_q <= hist_d;
         filt_q <= filt_d;
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q[1];
`endif

   // Delayed copy of the level for edge detection.
   always_comb begin
      prev_d = level;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign level_o = level;
   assign rise_o  = level & ~prev_q;
   assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target answering one 7-bit address; single-byte strobes towards the fabric.
// Optional SCL/SDA glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h42
) (
   input  logic       CLK_100MHz,
   input  logic       RST,
   inout  wire        I2C_SCL,
   inout  wire        I2C_SDA,
   input  logic [7:0] DATA_IN,
   output logic       RD_REQ,
   output logic [7:0] DATA_OUT,
   output logic       WR_VALID,
   output logic       BUSY
);

   logic scl_pin, sda_pin;
   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic bus_start, bus_stop;

   i2c_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [6:0] tx_q, tx_d;
   logic       sda_low_q, sda_low_d;
   logic [7:0] data_out_q, data_out_d;
   logic       wr_valid_q, wr_valid_d;
   logic       busy_q, busy_d;
   logic       rw_q, rw_d;
   logic       phase_q, phase_d;
   logic       load_tx;

   InOut u_scl_pad (
      .PORT  (I2C_SCL),
      .dataW (1'b0),
      .dir   (1'b0),
      .dataR (scl_pin)
   );

   InOut u_sda_pad (
      .PORT  (I2C_SDA),
      .dataW (1'b0),
      .dir   (sda_low_q),
      .dataR (sda_pin)
   );

   i2c_line_sync u_scl_sync (
      .clk_i   (CLK_100MHz),
      .rst_i   (RST),
      .line_i  (scl_pin),
      .level_o (scl_lvl),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk_i   (CLK_100MHz),
      .rst_i   (RST),
      .line_i  (sda_pin),
      .level_o (sda_lvl),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   assign bus_start = sda_fall & scl_lvl;
   assign bus_stop  = sda_rise & scl_lvl;

   // Bus FSM: START/STOP override the per-bit logic; phase_q splits the ACK slots in two.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      sda_low_d  = sda_low_q;
      data_out_d = data_out_q;
      wr_valid_d = 1'b0;
      busy_d     = busy_q;
      rw_d       = rw_q;
      phase_d    = phase_q;
      load_tx    = 1'b0;

      if (bus_stop) begin
         state_d   = StIdle;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
         phase_d   = 1'b0;
      end else if (bus_start) begin
         state_d   = StAddr;
         bit_cnt_d = 3'd7;
         sda_low_d = 1'b0;
         phase_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StAddr: begin
               if (scl_rise) begin
                  shift_d = {shift_q[5:0], sda_lvl};
                  if (bit_cnt_q == 3'd0) begin
                     if ((shift_q == TARGET_ADDR) && addr_supported(TARGET_ADDR)) begin
                        state_d = StAddrAck;
                        rw_d    = sda_lvl;
                        busy_d  = 1'b1;
                        phase_d = 1'b0;
                     end else begin
                        state_d   = StIdle;
                        sda_low_d = 1'b0;
                        busy_d    = 1'b0;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end
            StAddrAck: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_low_d = 1'b1;
                     phase_d   = 1'b1;
                  end else begin
                     phase_d   = 1'b0;
                     bit_cnt_d = 3'd7;
                     unique case (rw_q)
                        RW_WRITE: begin
                           sda_low_d = 1'b0;
                           state_d   = StWrite;
                        end
                        RW_READ: begin
                           load_tx   = 1'b1;
                           tx_d      = DATA_IN[6:0];
                           sda_low_d = ~DATA_IN[7];
                           state_d   = StRead;
                        end
                     endcase
                  end
               end
            end
            StWrite: begin
               if (scl_rise) begin
                  shift_d = {shift_q[5:0], sda_lvl};
                  if (bit_cnt_q == 3'd0) begin
                     data_out_d = {shift_q, sda_lvl};
                     wr_valid_d = 1'b1;
                     state_d    = StWriteAck;
                     phase_d    = 1'b0;
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end
            StWriteAck: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_low_d = 1'b1;
                     phase_d   = 1'b1;
                  end else begin
                     sda_low_d = 1'b0;
                     phase_d   = 1'b0;
                     bit_cnt_d = 3'd7;
                     state_d   = StWrite;
                  end
               end
            end
            StRead: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     sda_low_d = 1'b0;
                     phase_d   = 1'b0;
                     state_d   = StReadAck;
                  end else begin
                     sda_low_d = ~tx_q[6];
                     tx_d      = {tx_q[5:0], 1'b0};
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end
            StReadAck: begin
               if (scl_rise) begin
                  unique case (sda_lvl)
                     ACK:  phase_d = 1'b1;
                     NACK: begin
                        state_d   = StIdle;
                        sda_low_d = 1'b0;
                     end
                  endcase
               end else if (scl_fall && phase_q) begin
                  load_tx   = 1'b1;
                  tx_d      = DATA_IN[6:0];
                  sda_low_d = ~DATA_IN[7];
                  bit_cnt_d = 3'd7;
                  phase_d   = 1'b0;
                  state_d   = StRead;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State register with synchronous reset; SDA is released the cycle after RST.
   always_ff @(posedge CLK_100MHz) begin
      if (RST) begin
         state_q    <= StIdle;
         bit_cnt_q  <= 3'd7;
         shift_q    <= 7'd0;
         tx_q       <= 7'd0;
         sda_low_q  <= 1'b0;
         data_out_q <= 8'd0;
         wr_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
         phase_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         sda_low_q  <= sda_low_d;
         data_out_q <= data_out_d;
         wr_valid_q <= wr_valid_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
         phase_q    <= phase_d;
      end
   end

   assign RD_REQ   = load_tx & ~RST;
   assign DATA_OUT = data_out_q;
   assign WR_VALID = wr_valid_q;
   assign BUSY     = busy_q;

endmodule
